// File: rtl/matmul_scheduler.sv
// ============================================================================
// Module   : matmul_scheduler
// Brief    : Tile-grid walker for the blocked matmul array; issues A/B BRAM
//            reads per tile, aligns core strobes, hands off finished tiles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_scheduler #(
    parameter int BLOCK_SIZE        = 2,
    parameter int A_OUTER_DIMENSION = 6,
    parameter int B_OUTER_DIMENSION = 6,
    parameter int INNER_DIMENSION   = 64,
    parameter int NUM_CORES_A       = 4,
    parameter int NUM_CORES_B       = 1,
    parameter int ADDR_WIDTH_A      = 8,
    parameter int ADDR_WIDTH_B      = 8,
    parameter int RD_LATENCY        = 1,
    parameter int CORE_LATENCY      = 3,
    localparam int ROW_TILES = A_OUTER_DIMENSION / BLOCK_SIZE,
    localparam int COL_TILES = B_OUTER_DIMENSION / (BLOCK_SIZE * NUM_CORES_B),
    localparam int ROW_W     = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1,
    localparam int COL_W     = (COL_TILES > 1) ? $clog2(COL_TILES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    bram_en_a,
    output logic [ADDR_WIDTH_A-1:0] bram_addr_a,
    output logic                    bram_en_b,
    output logic [ADDR_WIDTH_B-1:0] bram_addr_b,
    output logic                    core_en,
    output logic                    core_first,
    output logic                    core_last,
    output logic                    tile_valid,
    input  logic                    tile_ready,
    output logic [ROW_W-1:0]        tile_row,
    output logic [COL_W-1:0]        tile_col
);

    localparam int unsigned K_STEPS = INNER_DIMENSION / (BLOCK_SIZE * NUM_CORES_A);
    localparam int C_K_W = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;
    localparam int C_D_W = $clog2(RD_LATENCY + CORE_LATENCY);
    localparam logic [C_K_W-1:0] C_K_LAST   = C_K_W'(K_STEPS - 1);
    localparam logic [C_D_W-1:0] C_D_LAST   = C_D_W'(RD_LATENCY + CORE_LATENCY - 1);
    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(ROW_TILES - 1);
    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(COL_TILES - 1);

    if ((INNER_DIMENSION % (BLOCK_SIZE * NUM_CORES_A)) != 0 ||
        (A_OUTER_DIMENSION % BLOCK_SIZE) != 0 ||
        (B_OUTER_DIMENSION % (BLOCK_SIZE * NUM_CORES_B)) != 0) begin : g_bad_division
        $error("matmul_scheduler: matrix dimensions are not exact multiples of the tiling");
    end
    if (64'(ROW_TILES * K_STEPS) > (64'(1) << ADDR_WIDTH_A) ||
        64'(COL_TILES * K_STEPS) > (64'(1) << ADDR_WIDTH_B)) begin : g_bad_addr_width
        $error("matmul_scheduler: BRAM address width too small for the tile grid");
    end
    if (RD_LATENCY < 1 || CORE_LATENCY < 1) begin : g_bad_latency
        $error("matmul_scheduler: latencies must be at least one cycle");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_DRAIN   = 3'd2,
        S_HANDOFF = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                  r_state_q, w_state_d;
    logic [ROW_W-1:0]        r_row_q, w_row_d;
    logic [COL_W-1:0]        r_col_q, w_col_d;
    logic [C_K_W-1:0]        r_k_q, w_k_d;
    logic [C_D_W-1:0]        r_d_q, w_d_d;

    logic                    r_busy_q, w_busy_d;
    logic                    r_done_q, w_done_d;
    logic                    r_tile_valid_q, w_tile_valid_d;
    logic                    r_bram_en_q, w_bram_en_d;
    logic                    r_issue_first_q, w_issue_first_d;
    logic                    r_issue_last_q, w_issue_last_d;
    logic [ADDR_WIDTH_A-1:0] r_addr_a_q, w_addr_a_d;
    logic [ADDR_WIDTH_B-1:0] r_addr_b_q, w_addr_b_d;

    logic [RD_LATENCY-1:0]   r_en_pipe_q, w_en_pipe_d;
    logic [RD_LATENCY-1:0]   r_first_pipe_q, w_first_pipe_d;
    logic [RD_LATENCY-1:0]   r_last_pipe_q, w_last_pipe_d;

    always_comb begin
        w_state_d = r_state_q;
        w_row_d   = r_row_q;
        w_col_d   = r_col_q;
        w_k_d     = r_k_q;
        w_d_d     = r_d_q;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_state_d = S_ISSUE;
                    w_row_d   = '0;
                    w_col_d   = '0;
                    w_k_d     = '0;
                end
            end
            S_ISSUE: begin
                if (r_k_q == C_K_LAST) begin
                    w_state_d = S_DRAIN;
                    w_k_d     = '0;
                    w_d_d     = '0;
                end else begin
                    w_k_d = r_k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_d_q == C_D_LAST) begin
                    w_state_d = S_HANDOFF;
                end else begin
                    w_d_d = r_d_q + 1'b1;
                end
            end
            S_HANDOFF: begin
                if (tile_ready) begin
                    w_state_d = S_ISSUE;
                    if (r_col_q == C_COL_LAST) begin
                        w_col_d = '0;
                        if (r_row_q == C_ROW_LAST) begin
                            w_row_d   = '0;
                            w_state_d = S_DONE;
                        end else begin
                            w_row_d = r_row_q + 1'b1;
                        end
                    end else begin
                        w_col_d = r_col_q + 1'b1;
                    end
                end
            end
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        w_busy_d        = (w_state_d == S_ISSUE) || (w_state_d == S_DRAIN) ||
                          (w_state_d == S_HANDOFF);
        w_done_d        = (w_state_d == S_DONE);
        w_tile_valid_d  = (w_state_d == S_HANDOFF);
        w_bram_en_d     = (w_state_d == S_ISSUE);
        w_issue_first_d = w_bram_en_d && (w_k_d == '0);
        w_issue_last_d  = w_bram_en_d && (w_k_d == C_K_LAST);
        w_addr_a_d      = '0;
        w_addr_b_d      = '0;
        if (w_bram_en_d) begin
            w_addr_a_d = ADDR_WIDTH_A'(K_STEPS * 32'(w_row_d) + 32'(w_k_d));
            w_addr_b_d = ADDR_WIDTH_B'(K_STEPS * 32'(w_col_d) + 32'(w_k_d));
        end
    end

    // Core strobes follow the issued reads by the BRAM read latency.
    always_comb begin
        w_en_pipe_d       = '0;
        w_first_pipe_d    = '0;
        w_last_pipe_d     = '0;
        w_en_pipe_d[0]    = r_bram_en_q;
        w_first_pipe_d[0] = r_issue_first_q;
        w_last_pipe_d[0]  = r_issue_last_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            w_en_pipe_d[i]    = r_en_pipe_q[i-1];
            w_first_pipe_d[i] = r_first_pipe_q[i-1];
            w_last_pipe_d[i]  = r_last_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= S_IDLE;
            r_row_q         <= '0;
            r_col_q         <= '0;
            r_k_q           <= '0;
            r_d_q           <= '0;
            r_busy_q        <= 1'b0;
            r_done_q        <= 1'b0;
            r_tile_valid_q  <= 1'b0;
            r_bram_en_q     <= 1'b0;
            r_issue_first_q <= 1'b0;
            r_issue_last_q  <= 1'b0;
            r_addr_a_q      <= '0;
            r_addr_b_q      <= '0;
            r_en_pipe_q     <= '0;
            r_first_pipe_q  <= '0;
            r_last_pipe_q   <= '0;
        end else begin
            r_state_q       <= w_state_d;
            r_row_q         <= w_row_d;
            r_col_q         <= w_col_d;
            r_k_q           <= w_k_d;
            r_d_q           <= w_d_d;
            r_busy_q        <= w_busy_d;
            r_done_q        <= w_done_d;
            r_tile_valid_q  <= w_tile_valid_d;
            r_bram_en_q     <= w_bram_en_d;
            r_issue_first_q <= w_issue_first_d;
            r_issue_last_q  <= w_issue_last_d;
            r_addr_a_q      <= w_addr_a_d;
            r_addr_b_q      <= w_addr_b_d;
            r_en_pipe_q     <= w_en_pipe_d;
            r_first_pipe_q  <= w_first_pipe_d;
            r_last_pipe_q   <= w_last_pipe_d;
        end
    end

    assign busy        = r_busy_q;
    assign done        = r_done_q;
    assign bram_en_a   = r_bram_en_q;
    assign bram_en_b   = r_bram_en_q;
    assign bram_addr_a = r_addr_a_q;
    assign bram_addr_b = r_addr_b_q;
    assign core_en     = r_en_pipe_q[RD_LATENCY-1];
    assign core_first  = r_first_pipe_q[RD_LATENCY-1];
    assign core_last   = r_last_pipe_q[RD_LATENCY-1];
    assign tile_valid  = r_tile_valid_q;
    assign tile_row    = r_row_q;
    assign tile_col    = r_col_q;

endmodule

`default_nettype wire

// File: tb/tb_matmul_scheduler.sv
// ============================================================================
// Module   : tb_matmul_scheduler
// Brief    : Directed bench for matmul_scheduler, default and RD=2/CORE=1 builds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_scheduler;

    localparam int K  = 8;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    logic start1, ready1, start2, ready2;

    logic          busy1, done1, ena1, enb1, cen1, cf1, cl1, tv1;
    logic [AW-1:0] aa1, ab1;
    logic [1:0]    tr1, tc1;
    logic          busy2, done2, ena2, enb2, cen2, cf2, cl2, tv2;
    logic [AW-1:0] aa2, ab2;
    logic [1:0]    tr2, tc2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matmul_scheduler u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .bram_en_a(ena1), .bram_addr_a(aa1), .bram_en_b(enb1), .bram_addr_b(ab1),
        .core_en(cen1), .core_first(cf1), .core_last(cl1),
        .tile_valid(tv1), .tile_ready(ready1), .tile_row(tr1), .tile_col(tc1)
    );

    matmul_scheduler #(.RD_LATENCY(2), .CORE_LATENCY(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .bram_en_a(ena2), .bram_addr_a(aa2), .bram_en_b(enb2), .bram_addr_b(ab2),
        .core_en(cen2), .core_first(cf2), .core_last(cl2),
        .tile_valid(tv2), .tile_ready(ready2), .tile_row(tr2), .tile_col(tc2)
    );

    task automatic chk(input string tag, input int c, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one matmul from IDLE; cycle 0 is the cycle in which start is driven.
    task automatic run(input bit sel, input int stall_tile, input int stall_len,
                       input int start2_cyc, input int rst_cyc,
                       output int done_at, output int n_done, output int n_tiles);
        int rd, cl, done_cyc, last_c, e_aa, e_ab, e_tr, e_tc;
        int s[9];
        int h[9];
        int acc[9];
        logic rdy, st, e_en, e_cen, e_cf, e_cl, e_tv, e_busy, e_done, aborted;
        logic o_busy, o_done, o_ena, o_enb, o_cen, o_cf, o_cl, o_tv;
        logic [AW-1:0] o_aa, o_ab;
        logic [1:0] o_tr, o_tc;
        rd = sel ? 2 : 1;
        cl = sel ? 1 : 3;
        s[0] = 1;
        for (int n = 0; n < 9; n++) begin
            h[n]   = s[n] + K + rd + cl;
            acc[n] = h[n] + ((n == stall_tile) ? stall_len : 0);
            if (n < 8) s[n+1] = acc[n] + 1;
        end
        done_cyc = acc[8] + 1;
        last_c   = (rst_cyc >= 0) ? rst_cyc + 6 : done_cyc + 3;
        done_at  = -1;
        n_done   = 0;
        n_tiles  = 0;
        for (int c = 0; c <= last_c; c++) begin
            st  = (c == 0) || (c == start2_cyc);
            rdy = !(stall_tile >= 0 && c >= h[stall_tile] && c < h[stall_tile] + stall_len);
            rst = (c == rst_cyc);
            if (sel) begin start2 = st; ready2 = rdy; end
            else     begin start1 = st; ready1 = rdy; end
            o_busy = sel ? busy2 : busy1;  o_done = sel ? done2 : done1;
            o_ena  = sel ? ena2  : ena1;   o_enb  = sel ? enb2  : enb1;
            o_aa   = sel ? aa2   : aa1;    o_ab   = sel ? ab2   : ab1;
            o_cen  = sel ? cen2  : cen1;   o_cf   = sel ? cf2   : cf1;
            o_cl   = sel ? cl2   : cl1;    o_tv   = sel ? tv2   : tv1;
            o_tr   = sel ? tr2   : tr1;    o_tc   = sel ? tc2   : tc1;

            aborted = (rst_cyc >= 0) && (c > rst_cyc);
            e_en = 0; e_cen = 0; e_cf = 0; e_cl = 0; e_tv = 0;
            e_aa = 0; e_ab = 0; e_tr = 0; e_tc = 0;
            if (!aborted) begin
                for (int n = 0; n < 9; n++) begin
                    if (c >= s[n] && c <= s[n] + K - 1) begin
                        e_en = 1;
                        e_aa = (n / 3) * K + (c - s[n]);
                        e_ab = (n % 3) * K + (c - s[n]);
                    end
                    if (c >= s[n] + rd && c <= s[n] + K - 1 + rd) begin
                        e_cen = 1;
                        e_cf  = (c == s[n] + rd);
                        e_cl  = (c == s[n] + K - 1 + rd);
                    end
                    if (c >= h[n] && c <= acc[n]) begin
                        e_tv = 1; e_tr = n / 3; e_tc = n % 3;
                    end
                end
            end
            e_busy = !aborted && (c >= 1) && (c <= acc[8]);
            e_done = !aborted && (c == done_cyc);

            chk("busy", c, 32'(o_busy), 32'(e_busy));
            chk("done", c, 32'(o_done), 32'(e_done));
            chk("bram_en_a", c, 32'(o_ena), 32'(e_en));
            chk("bram_en_b", c, 32'(o_enb), 32'(e_en));
            chk("core_en", c, 32'(o_cen), 32'(e_cen));
            chk("core_first", c, 32'(o_cf), 32'(e_cf));
            chk("core_last", c, 32'(o_cl), 32'(e_cl));
            chk("tile_valid", c, 32'(o_tv), 32'(e_tv));
            if (e_en || aborted) begin
                chk("bram_addr_a", c, 32'(o_aa), 32'(e_aa));
                chk("bram_addr_b", c, 32'(o_ab), 32'(e_ab));
            end
            if (e_tv || aborted) begin
                chk("tile_row", c, 32'(o_tr), 32'(e_tr));
                chk("tile_col", c, 32'(o_tc), 32'(e_tc));
            end
            if (o_tv === 1'b1 && rdy) begin
                chk("order_row", c, 32'(o_tr), 32'(n_tiles / 3));
                chk("order_col", c, 32'(o_tc), 32'(n_tiles % 3));
                n_tiles++;
            end
            if (o_done === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            step();
        end
        rst    = 1'b0;
        start1 = 1'b0; ready1 = 1'b1;
        start2 = 1'b0; ready2 = 1'b1;
    endtask

    initial begin
        int d_at, nd, nt;
        rst = 1'b1; start1 = 1'b0; ready1 = 1'b1; start2 = 1'b0; ready2 = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        step();

        chk("rst_busy", 0, 32'(busy1), 0);
        chk("rst_done", 0, 32'(done1), 0);
        chk("rst_bram_en", 0, 32'({ena1, enb1}), 0);
        chk("rst_addr", 0, 32'({aa1, ab1}), 0);
        chk("rst_core", 0, 32'({cen1, cf1, cl1}), 0);
        chk("rst_tile", 0, 32'({tv1, tr1, tc1}), 0);
        chk("rst_dut2", 0, 32'({busy2, done2, ena2, cen2, tv2, aa2, ab2}), 0);

        // Defaults, ready held high: nine tiles, done at cycle 118.
        run(1'b0, -1, 0, -1, -1, d_at, nd, nt);
        chk("basic_done_cycle", 0, 32'(d_at), 118);
        chk("basic_done_count", 0, 32'(nd), 1);
        chk("basic_tiles", 0, 32'(nt), 9);

        // Five-cycle backpressure on tile (0,1) delays done by exactly five.
        run(1'b0, 1, 5, -1, -1, d_at, nd, nt);
        chk("stall_done_cycle", 0, 32'(d_at), 123);
        chk("stall_tiles", 0, 32'(nt), 9);

        // Second start pulse while busy is ignored.
        run(1'b0, -1, 0, 20, -1, d_at, nd, nt);
        chk("restart_done_cycle", 0, 32'(d_at), 118);
        chk("restart_done_count", 0, 32'(nd), 1);
        chk("restart_tiles", 0, 32'(nt), 9);

        // Reset during the issue phase of tile (0,2) aborts with no done.
        run(1'b0, -1, 0, -1, 30, d_at, nd, nt);
        chk("abort_done_count", 0, 32'(nd), 0);
        chk("abort_tiles", 0, 32'(nt), 2);

        // After the abort a fresh start begins again at tile (0,0).
        run(1'b0, -1, 0, -1, -1, d_at, nd, nt);
        chk("post_abort_done_cycle", 0, 32'(d_at), 118);
        chk("post_abort_tiles", 0, 32'(nt), 9);

        // RD_LATENCY=2, CORE_LATENCY=1: twelve-cycle tiles, done at 109.
        run(1'b1, -1, 0, -1, -1, d_at, nd, nt);
        chk("lat_done_cycle", 0, 32'(d_at), 109);
        chk("lat_done_count", 0, 32'(nd), 1);
        chk("lat_tiles", 0, 32'(nt), 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
